// File: rtl/lakespec_cfg_sequencer.sv
// Config-word assembler and flush/run sequencer for the lakespec static memory tile.
// Shadow words are committed atomically to cfg_out on start, then flush and run phases are timed.
module lakespec_cfg_sequencer #(
   parameter int unsigned CONFIG_WIDTH = 550,
   parameter int unsigned WORD_WIDTH   = 32,
   parameter int unsigned FLUSH_CYCLES = 4,
   parameter int unsigned COUNT_WIDTH  = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             config_addr,
   input  logic [WORD_WIDTH-1:0]   config_data,
   input  logic                    config_write,
   input  logic                    config_read,
   output logic [WORD_WIDTH-1:0]   config_rd_data,
   input  logic                    start,
   input  logic                    abort,
   input  logic [31:0]             run_cycles,
   output logic [CONFIG_WIDTH-1:0] cfg_out,
   output logic                    flush,
   output logic                    run,
   output logic                    busy,
   output logic                    done,
   output logic [COUNT_WIDTH-1:0]  cycle_count,
   output logic                    err
);

   localparam int unsigned NUM_WORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
   localparam int unsigned ADDR_W    = $clog2(NUM_WORDS);
   localparam int unsigned LAST_BITS = CONFIG_WIDTH - (NUM_WORDS - 1) * WORD_WIDTH;
   localparam logic [WORD_WIDTH-1:0] LAST_MASK = {WORD_WIDTH{1'b1}} >> (WORD_WIDTH - LAST_BITS);

   typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_RUN, S_DONE} state_t;

   state_t                  state, state_nxt;
   logic [WORD_WIDTH-1:0]   shadow [NUM_WORDS];
   logic [CONFIG_WIDTH-1:0] shadow_cfg;
   logic [31:0]             run_len;
   logic [7:0]              flush_cnt;
   logic [ADDR_W-1:0]       addr_idx;
   logic                    addr_ok;
   logic                    in_seq;
   logic                    wr_en;
   logic                    commit;
   logic                    err_set;

   assign addr_ok  = config_addr < 32'(NUM_WORDS);
   assign addr_idx = config_addr[ADDR_W-1:0];
   assign in_seq   = (state == S_FLUSH) || (state == S_RUN);

   // Flatten shadow words into the config word; last word contributes only its live bits
   always_comb begin
      shadow_cfg = '0;
      for (int k = 0; k < int'(NUM_WORDS) - 1; k++)
         shadow_cfg[k*WORD_WIDTH +: WORD_WIDTH] = shadow[k];
      shadow_cfg[CONFIG_WIDTH-1 -: LAST_BITS] = shadow[NUM_WORDS-1][LAST_BITS-1:0];
   end

   // Next state; abort overrides start and writes
   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      commit    = 1'b0;
      err_set   = 1'b0;
      if (config_read && !addr_ok)
         err_set = 1'b1;
      if (abort) begin
         state_nxt = S_IDLE;
      end else begin
         if (config_write) begin
            if (in_seq || !addr_ok) begin
               err_set = 1'b1;
            end else begin
               wr_en = 1'b1;
               if (state == S_DONE)
                  state_nxt = S_IDLE;
            end
         end
         if (start) begin
            if (in_seq) begin
               err_set = 1'b1;
            end else begin
               commit    = 1'b1;
               state_nxt = S_FLUSH;
            end
         end
         case (state)
            S_FLUSH: if (flush_cnt == 8'(FLUSH_CYCLES - 1))
                        state_nxt = (run_len != 32'd0) ? S_RUN : S_DONE;
            S_RUN:   if ((cycle_count + COUNT_WIDTH'(1)) >= COUNT_WIDTH'(run_len))
                        state_nxt = S_DONE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Datapath and registered phase outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < int'(NUM_WORDS); k++)
            shadow[k] <= '0;
         cfg_out        <= '0;
         config_rd_data <= '0;
         run_len        <= '0;
         flush_cnt      <= '0;
         cycle_count    <= '0;
         err            <= 1'b0;
         flush          <= 1'b0;
         run            <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         flush <= (state_nxt == S_FLUSH);
         run   <= (state_nxt == S_RUN);
         busy  <= (state_nxt == S_FLUSH) || (state_nxt == S_RUN);
         done  <= (state_nxt == S_DONE);
         if (err_set)
            err <= 1'b1;
         if (config_read)
            config_rd_data <= addr_ok ? shadow[addr_idx] : '0;
         if (wr_en)
            shadow[addr_idx] <= (addr_idx == ADDR_W'(NUM_WORDS - 1)) ? (config_data & LAST_MASK)
                                                                     : config_data;
         if (commit) begin
            cfg_out     <= shadow_cfg;
            run_len     <= run_cycles;
            flush_cnt   <= '0;
            cycle_count <= '0;
         end else begin
            if (state == S_FLUSH)
               flush_cnt <= flush_cnt + 8'd1;
            // A RUN cycle still counts when it is the one cut short by abort
            if (state == S_RUN && cycle_count != {COUNT_WIDTH{1'b1}})
               cycle_count <= cycle_count + COUNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_lakespec_cfg_sequencer.sv
// Scoreboard bench for lakespec_cfg_sequencer: readback and per-cycle phase expectations
// are queued when stimulus is driven and compared as the DUT produces them.
module tb_lakespec_cfg_sequencer;

   localparam int unsigned CW = 550;
   localparam int unsigned WW = 32;
   localparam int unsigned NW = 18;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   config_addr;
   logic [WW-1:0] config_data;
   logic          config_write;
   logic          config_read;
   logic [WW-1:0] config_rd_data;
   logic          start;
   logic          abort;
   logic [31:0]   run_cycles;
   logic [CW-1:0] cfg_out;
   logic          flush;
   logic          run;
   logic          busy;
   logic          done;
   logic [63:0]   cycle_count;
   logic          err;

   lakespec_cfg_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .config_addr    (config_addr),
      .config_data    (config_data),
      .config_write   (config_write),
      .config_read    (config_read),
      .config_rd_data (config_rd_data),
      .start          (start),
      .abort          (abort),
      .run_cycles     (run_cycles),
      .cfg_out        (cfg_out),
      .flush          (flush),
      .run            (run),
      .busy           (busy),
      .done           (done),
      .cycle_count    (cycle_count),
      .err            (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        f;
      logic        r;
      logic        d;
      logic [63:0] cnt;
   } step_t;

   int            n_cmp = 0;
   int            n_bad = 0;
   step_t         tl [$];
   logic [WW-1:0] rdq [$];
   logic [WW-1:0] sh [NW];
   logic [CW-1:0] cfg_exp;

   task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [CW-1:0] pack_sh();
      logic [CW-1:0] p;
      p = '0;
      for (int k = 0; k < int'(NW) - 1; k++)
         p[k*WW +: WW] = sh[k];
      p[CW-1 -: 6] = sh[NW-1][5:0];
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [WW-1:0] d);
      config_addr  = a;
      config_data  = d;
      config_write = 1'b1;
      tick();
      config_write = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a);
      config_addr = a;
      config_read = 1'b1;
      if (a < NW) rdq.push_back(sh[a]);
      else        rdq.push_back('0);
      tick();
      config_read = 1'b0;
      check($sformatf("rd[%0d]", a), config_rd_data, rdq.pop_front());
   endtask

   task automatic push_flush();
      step_t s;
      for (int i = 0; i < 4; i++) begin
         s = '{f: 1'b1, r: 1'b0, d: 1'b0, cnt: 64'd0};
         tl.push_back(s);
      end
   endtask

   task automatic push_seq(input int rc);
      step_t s;
      push_flush();
      for (int i = 0; i < rc; i++) begin
         s = '{f: 1'b0, r: 1'b1, d: 1'b0, cnt: 64'(i)};
         tl.push_back(s);
      end
      s = '{f: 1'b0, r: 1'b0, d: 1'b1, cnt: 64'(rc)};
      tl.push_back(s);
   endtask

   task automatic check_step();
      step_t s;
      s = tl.pop_front();
      check("flush", flush, s.f);
      check("run", run, s.r);
      check("done", done, s.d);
      check("busy", busy, s.f | s.r);
      check("cycle_count", cycle_count, s.cnt);
   endtask

   task automatic pulse_start(input int rc);
      run_cycles = 32'(rc);
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic drain();
      while (tl.size() != 0) begin
         check_step();
         if (tl.size() != 0) tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      config_addr = '0; config_data = '0; config_write = 1'b0; config_read = 1'b0;
      start = 1'b0; abort = 1'b0; run_cycles = '0;
      for (int k = 0; k < int'(NW); k++) sh[k] = '0;
      tick();
      tick();
      check("rst_flush", flush, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_cfg", cfg_out, '0);
      check("rst_err", err, 1'b0);
      rst = 1'b0;
      tick();

      // Fill all words and read them back; last word keeps only 6 bits
      for (int k = 0; k < int'(NW); k++) begin
         do_write(32'(k), 32'hA5A5_0000 + 32'(k));
         sh[k] = (k == int'(NW) - 1) ? ((32'hA5A5_0000 + 32'(k)) & 32'h3F) : (32'hA5A5_0000 + 32'(k));
      end
      for (int k = 0; k < int'(NW); k++) do_read(32'(k));
      check("cfg_before_start", cfg_out, '0);

      // Normal sequence with 10 run cycles
      cfg_exp = pack_sh();
      push_seq(10);
      pulse_start(10);
      drain();
      check("cfg_commit", cfg_out, cfg_exp);

      // Zero-length run from DONE, with a same-cycle write to word 0
      cfg_exp = pack_sh();
      push_seq(0);
      config_addr = 32'd0; config_data = 32'h1234_5678; config_write = 1'b1;
      pulse_start(0);
      config_write = 1'b0;
      sh[0] = 32'h1234_5678;
      drain();
      check("cfg_prewrite", cfg_out, cfg_exp);
      do_read(32'd0);
      check("err_clean", err, 1'b0);

      // Writes and start during RUN are ignored and flag err
      push_seq(10);
      pulse_start(10);
      for (int i = 0; tl.size() != 0; i++) begin
         check_step();
         if (tl.size() != 0) begin
            if (i == 5) begin config_addr = 32'd3; config_data = 32'hDEAD_BEEF; config_write = 1'b1; end
            if (i == 6) start = 1'b1;
            if (i == 7) begin config_addr = 32'd18; config_data = 32'h1; config_write = 1'b1; end
            tick();
            config_write = 1'b0;
            start = 1'b0;
         end
      end
      check("err_sticky", err, 1'b1);
      do_read(32'd3);
      do_read(32'd18);

      // Abort on the 5th RUN cycle
      push_flush();
      for (int i = 0; i < 5; i++) tl.push_back('{f: 1'b0, r: 1'b1, d: 1'b0, cnt: 64'(i)});
      pulse_start(10);
      drain();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_run", run, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_cnt", cycle_count, 64'd5);
      tick();
      check("abort_cnt_hold", cycle_count, 64'd5);
      push_seq(3);
      pulse_start(3);
      drain();

      // Asynchronous reset mid-FLUSH
      pulse_start(10);
      check("pre_rst_flush", flush, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("async_flush", flush, 1'b0);
      check("async_busy", busy, 1'b0);
      check("async_cfg", cfg_out, '0);
      check("async_cnt", cycle_count, 64'd0);
      check("async_err", err, 1'b0);
      check("async_rd", config_rd_data, '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < int'(NW); k++) sh[k] = '0;
      push_seq(2);
      pulse_start(2);
      drain();
      check("cfg_zero", cfg_out, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lakespec_cfg_sequencer.md
Name: lakespec_cfg_sequencer

Overview:
- Front-end controller for the lakespec static memory tile.
- Accepts 32-bit addressed config writes and assembles them into the wide `config_memory_size` word.
- Commits that word atomically, then sequences the tile's `flush` and run phases.
- Counts run cycles and raises `done`, replacing bench-driven bitstream loading and flush timing.

Parameters:
- CONFIG_WIDTH, 550, width of the assembled config word driven to lakespec.
- WORD_WIDTH, 32, width of one config data word.
- NUM_WORDS, ceil(CONFIG_WIDTH/WORD_WIDTH) = 18, number of addressable config words.
- FLUSH_CYCLES, 4, cycles `flush` is held high before run (legal range 1..255).
- COUNT_WIDTH, 64, width of `cycle_count`.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- config_addr  in  32  config word index (word address, not byte address).
- config_data  in  WORD_WIDTH  config write data.
- config_write  in  1  write strobe, one word per cycle.
- config_read  in  1  read strobe.
- config_rd_data  out  WORD_WIDTH  readback data, valid the cycle after `config_read`.
- start  in  1  single-cycle pulse: commit config and begin the flush/run sequence.
- abort  in  1  force return to IDLE.
- run_cycles  in  32  run-phase length; sampled on an accepted `start`.
- cfg_out  out  CONFIG_WIDTH  committed config, connected to `lakespec.config_memory_size_550`.
- flush  out  1  flush to lakespec.
- run  out  1  high during run phase; qualifies lakespec port data.
- busy  out  1  high in FLUSH or RUN.
- done  out  1  high in DONE.
- cycle_count  out  COUNT_WIDTH  run cycles elapsed in the current or last sequence.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, rst=1): state=IDLE; shadow regs, `cfg_out`, `config_rd_data`, `cycle_count`, `err` all 0; `flush`, `run`, `busy`, `done` all 0. Reset mid-sequence drops `flush`/`run` immediately (async).
- Storage: shadow array of NUM_WORDS words, plus active register `cfg_out`.
  - Word k maps to `cfg_out[k*WORD_WIDTH +: WORD_WIDTH]`.
  - The last word is truncated to CONFIG_WIDTH; its unused upper bits are written as 0 and read back as 0.
- Write accepted (state IDLE or DONE, `config_addr` < NUM_WORDS): shadow[addr] <= `config_data` at the edge. `cfg_out` is not changed.
  - Write while in DONE: also moves state to IDLE and clears `done`.
- Write rejected (`config_addr` >= NUM_WORDS, or state FLUSH/RUN): ignored; `err` <= 1.
- Read: `config_rd_data` <= shadow[addr] one cycle after `config_read`.
  - Out-of-range address returns 0 and sets `err`.
  - Reads are allowed in any state.
  - `config_rd_data` holds its value when no read is issued.
- Read and write to the same address in the same cycle: read returns the old value.
- State machine:
  - IDLE --start--> FLUSH. On that edge: `cfg_out` <= shadow; run length latched from `run_cycles`; flush counter=0; `cycle_count` <= 0.
  - FLUSH: `flush`=1, `busy`=1. Exits after exactly FLUSH_CYCLES cycles: to RUN if latched run length > 0, else to DONE.
  - RUN: `run`=1, `busy`=1. `cycle_count` increments by 1 each RUN cycle. After the latched number of cycles, go to DONE; `cycle_count` then equals `run_cycles`.
  - DONE: `done`=1. `cycle_count` holds. `start` re-enters FLUSH (recommit, clear count).
- `start` in FLUSH/RUN: ignored; `err` <= 1.
- `abort` (any state): next edge goes to IDLE; `flush`, `run`, `done` deassert; `cycle_count` and `cfg_out` hold. `abort` takes priority over `start` and writes in the same cycle.
- `start` and `config_write` in the same cycle (IDLE/DONE): the write lands in shadow, and the commit uses the pre-write shadow value.
- Outputs are registered and decoded from state: `flush` rises the cycle after `start`; `run` rises the cycle after the last `flush` cycle (no gap, no overlap).
- `cycle_count` saturates at all-ones.
- `err` clears only on reset.

Test Plan:
- Reset then write words 0..17 with `0xA5A50000 + k` and read all back → each readback matches one cycle later; word 17 reads `0x00000000 | (data & 0x3F)` (550 = 17*32 + 6); `cfg_out` stays 0 until `start`.
- Pulse `start` with `run_cycles`=10 → `flush` high for exactly 4 cycles starting the cycle after `start`; `run` high for 10 cycles immediately after; `done`=1 with `cycle_count`=10; `cfg_out` equals the written shadow.
- `run_cycles`=0 → 4 `flush` cycles, then DONE directly with `run` never asserted and `cycle_count`=0.
- During RUN: issue a write to addr 3, a `start`, and a write to addr 18 → all ignored, `err`=1, shadow[3] unchanged, sequence finishes on schedule.
- `abort` on the 5th RUN cycle → `run` low next cycle, state IDLE, `cycle_count`=5 held; a new `start` restarts with `cycle_count` cleared to 0.
- Assert `rst` asynchronously mid-FLUSH (between clock edges) → `flush` drops at once and all outputs read 0; after release, a `start` commits an all-zero `cfg_out`.
